// File: rtl/mover_cmd_arbiter.sv
// Round-robin arbiter feeding a single data-mover command port.
// One command is held in an output register. Issued-but-not-done commands
// are tracked so that no more than MAX_OUTSTANDING are ever in flight.
// A requester whose accepted command has the last flag (bit 55) clear keeps
// ownership until it sends a command with the last flag set.
module mover_cmd_arbiter #(
  parameter int N_REQ           = 2,
  parameter int CMD_WIDTH       = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [N_REQ*CMD_WIDTH-1:0]   req_cmd,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  output logic [CMD_WIDTH-1:0]         cmd,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [$clog2(N_REQ)-1:0]     cmd_src,
  input  logic                         done,
  output logic [3:0]                   outstanding,
  output logic                         err_underflow
);

  localparam int SRC_W    = $clog2(N_REQ);
  localparam int LAST_BIT = 55;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e               state_q;
  logic [CMD_WIDTH-1:0] cmd_q;
  logic                 cmd_valid_q;
  logic [SRC_W-1:0]     cmd_src_q;
  logic [SRC_W-1:0]     last_grant_q;
  logic [SRC_W-1:0]     lock_id_q;
  logic [3:0]           outstanding_q;
  logic [3:0]           outstanding_d;
  logic                 err_q;
  logic                 err_d;

  logic                 issue;
  logic                 reg_free;
  logic [4:0]           in_flight;
  logic                 can_accept;
  logic                 grant_valid;
  logic [SRC_W-1:0]     grant_idx;
  logic [SRC_W-1:0]     cand;
  logic                 accept;
  logic [CMD_WIDTH-1:0] sel_cmd;
  logic                 sel_last;

  // The held command always leaves eventually, so it is counted as in flight
  // alongside the issued ones; this keeps the count within the limit even
  // when an issue and an accept share a cycle.
  assign issue      = cmd_valid_q & cmd_ready;
  assign reg_free   = ~cmd_valid_q | cmd_ready;
  assign in_flight  = {1'b0, outstanding_q} + {4'b0000, cmd_valid_q};
  assign can_accept = reg_free & (in_flight < 5'(MAX_OUTSTANDING));

  // Pick the requester to serve: the lock owner when locked, otherwise the
  // first valid requester after the previous winner, wrapping around.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (state_q == LOCKED) begin
      grant_idx   = lock_id_q;
      grant_valid = req_valid[lock_id_q];
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = SRC_W'((int'(last_grant_q) + k) % N_REQ);
        if (!grant_valid && req_valid[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  // Only the granted requester sees ready, and nobody does while in reset.
  always_comb begin
    req_ready = '0;
    if (aresetn && can_accept && grant_valid) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept   = aresetn & can_accept & grant_valid;
  assign sel_cmd  = req_cmd[int'(grant_idx)*CMD_WIDTH +: CMD_WIDTH];
  assign sel_last = sel_cmd[LAST_BIT];

  // Outstanding counter: an issue and a completion in the same cycle cancel.
  // A completion with nothing outstanding is flagged and the count stays 0.
  always_comb begin
    outstanding_d = outstanding_q;
    err_d         = err_q;
    if (issue && !done) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!issue && done) begin
      if (outstanding_q == 4'd0) begin
        err_d = 1'b1;
      end else begin
        outstanding_d = outstanding_q - 4'd1;
      end
    end
  end

  // All registered state: output command slot, lock FSM and counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_src_q     <= '0;
      last_grant_q  <= SRC_W'(N_REQ - 1);
      lock_id_q     <= '0;
      outstanding_q <= 4'd0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      if (accept) begin
        cmd_q        <= sel_cmd;
        cmd_src_q    <= grant_idx;
        cmd_valid_q  <= 1'b1;
        last_grant_q <= grant_idx;
        case (state_q)
          IDLE: begin
            if (!sel_last) begin
              state_q   <= LOCKED;
              lock_id_q <= grant_idx;
            end
          end
          LOCKED: begin
            if (sel_last) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (issue) begin
        cmd_valid_q <= 1'b0;
      end
    end
  end

  assign cmd           = cmd_q;
  assign cmd_valid     = cmd_valid_q;
  assign cmd_src       = cmd_src_q;
  assign outstanding   = outstanding_q;
  assign err_underflow = err_q;

endmodule
